nanci_sort_pe: RTL and testbench
================================

Name: nanci_sort_pe

Overview:
- Parametrised mesh processing element for the Nanci SQRT_N x SQRT_N array.
- Holds one {addr,data} word and exchanges it with its four neighbours (l/r/u/d).
- Supports load, single-cycle directional shifts, and a multi-cycle lockstep shearsort.
- Shearsort uses odd-even transposition in alternating row/column phases with snake row order.
- Every PE in the array receives the same command in the same cycle.

Parameters:
- SQRT_N, 4, mesh side length (>=1).
- ROW, 0, row index of this PE (0..SQRT_N-1).
- COL, 0, column index of this PE (0..SQRT_N-1).
- ADDR_WIDTH, 3, key field width (upper bits of the word).
- DATA_WIDTH, 3, payload width (lower bits of the word).
- PHASES, 5, number of sort phases; 2*clog2(SQRT_N)+1; must be odd.
- RESET_VALUE, 0, o_PE value on reset (W bits).
- Derived: W = ADDR_WIDTH+DATA_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_cmd  in  3  command: 0 NOP, 1 LOAD, 2 SHIFT_L, 3 SHIFT_R, 4 SHIFT_U, 5 SHIFT_D, 6 SORT, 7 NOP.
- i_load  in  W  value captured on LOAD.
- i_PE_l  in  W  left neighbour's o_PE.
- i_PE_r  in  W  right neighbour's o_PE.
- i_PE_u  in  W  upper neighbour's o_PE.
- i_PE_d  in  W  lower neighbour's o_PE.
- o_PE  out  W  registered held word.
- o_busy  out  1  high while the sort is running or completing.
- o_done  out  1  one-cycle pulse at sort completion.

Behaviour:
- Reset (rst=0, async): o_PE=RESET_VALUE, o_busy=0, o_done=0, state=IDLE, step=0, phase=0. A reset during a sort aborts it; no done pulse is produced.
- All outputs are registered. Comparisons are unsigned on the full W-bit word, so equal words tie consistently.
- IDLE state:
  - LOAD: o_PE<=i_load next edge.
  - SHIFT_x: o_PE<=i_PE_x next edge (SHIFT_L takes the left neighbour's value). Edge PEs also take the input port; the mesh ties off edges.
  - SORT: state<=SORT, step<=0, phase<=0, o_busy<=1.
  - NOP/7: hold.
- SORT state: one exchange per cycle, with step s, phase p.
  - Row phase (p even):
    - If (COL+s) is even and COL<SQRT_N-1, partner = r. If (COL+s) is odd and COL>0, partner = l. Otherwise hold.
    - Row ascending iff ROW is even.
    - Partner r: keep min if ascending, else max. Partner l: keep max if ascending, else min.
  - Column phase (p odd):
    - If (ROW+s) is even and ROW<SQRT_N-1, partner = d; keep min.
    - If (ROW+s) is odd and ROW>0, partner = u; keep max.
    - Otherwise hold.
  - Counters: step increments each cycle. At s=SQRT_N-1, step<=0 and phase++. At p=PHASES-1 and s=SQRT_N-1, state<=DONE.
  - i_cmd is ignored in SORT and DONE.
- DONE state: o_done=1 for exactly one cycle, o_busy stays 1, then state<=IDLE with o_busy=0 and o_done=0.
- Latency: a SORT sampled at edge t gives exchanges at edges t+1..t+PHASES*SQRT_N. o_done is high during the following cycle. o_busy is high for PHASES*SQRT_N+1 cycles.
- SQRT_N=1: no partners exist; the value is unchanged and done follows after PHASES cycles.
- Result: after the sort, the array holds the words in snake order. Rows are ascending left-to-right on even rows and right-to-left on odd rows, and all of row k is <= all of row k+1.
- Counter widths: step is max(1,clog2(SQRT_N)), phase is max(1,clog2(PHASES)). No wrap occurs beyond the terminal values.

Test Plan:
- Single PE, SQRT_N=1, neighbours l=6'b000_001, r=6'b000_010, u=6'b000_011, d=6'b000_100: hold rst low 2 cycles, then SHIFT_L -> o_PE=1. SHIFT_R -> 2. SHIFT_U -> 3. SHIFT_D -> 4.
- Reset values: RESET_VALUE=6'b111_000 -> o_PE=56, o_busy=0, o_done=0 while rst=0. Assert rst mid-cycle -> outputs clear without waiting for a clock edge.
- LOAD i_load=6'b101_010 -> o_PE=42 next edge. Then NOP for 3 cycles -> o_PE stays 42.
- 2x2 mesh, PHASES=3, LOAD keys 3,2,1,0 (data 0) at (0,0),(0,1),(1,0),(1,1), then SORT:
  - o_busy is high for 7 cycles and o_done pulses on the 7th.
  - Final values: (0,0)=0, (0,1)=8, (1,1)=16, (1,0)=24.
  - After phase 0, values are 16,24,8,0.
- SORT issued during a sort, and LOAD issued while busy, are both ignored: the final result is unchanged. Reset asserted at exchange 3 -> state IDLE, no o_done, o_PE=RESET_VALUE.
- 4x4 mesh, PHASES=5, load a random permutation of 16 keys: o_done arrives 21 cycles after SORT, and the snake-order readout is strictly ascending. Repeat with duplicate keys and differing data: the readout is non-decreasing and the multiset of words is preserved.

Source files
------------

// File: rtl/nanci_sort_pe.sv
// One processing element of the Nanci SQRT_N x SQRT_N mesh. It holds one {addr,data} word,
// exchanges it with its four neighbours, and runs a lockstep snake-order shearsort.
module nanci_sort_pe #(
   parameter int SQRT_N     = 4,
   parameter int ROW        = 0,
   parameter int COL        = 0,
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 3,
   parameter int PHASES     = 5,
   parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [2:0]                       i_cmd,
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_load,
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_l,
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_r,
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_u,
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_d,
   output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_PE,
   output logic                             o_busy,
   output logic                             o_done
);

   localparam int W  = ADDR_WIDTH + DATA_WIDTH;
   localparam int SW = (SQRT_N > 1) ? $clog2(SQRT_N) : 1;
   localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;

   localparam logic [2:0] CMD_LOAD    = 3'd1;
   localparam logic [2:0] CMD_SHIFT_L = 3'd2;
   localparam logic [2:0] CMD_SHIFT_R = 3'd3;
   localparam logic [2:0] CMD_SHIFT_U = 3'd4;
   localparam logic [2:0] CMD_SHIFT_D = 3'd5;
   localparam logic [2:0] CMD_SORT    = 3'd6;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SORT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Neighbour existence and parity are fixed by this PE's position in the mesh.
   localparam bit HAS_L   = (COL > 0);
   localparam bit HAS_R   = (COL < SQRT_N - 1);
   localparam bit HAS_U   = (ROW > 0);
   localparam bit HAS_D   = (ROW < SQRT_N - 1);
   localparam bit COL_ODD = ((COL % 2) == 1);
   localparam bit ROW_ODD = ((ROW % 2) == 1);
   localparam bit ASCEND  = !ROW_ODD;

   localparam logic [SW-1:0] STEP_LAST  = SW'(SQRT_N - 1);
   localparam logic [PW-1:0] PHASE_LAST = PW'(PHASES - 1);

   logic [1:0]    state_q, state_d;
   logic [SW-1:0] step_q, step_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [W-1:0]  pe_q, pe_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          colEven, rowEven;

   assign colEven = (step_q[0] ^ COL_ODD) == 1'b0;
   assign rowEven = (step_q[0] ^ ROW_ODD) == 1'b0;

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      phase_d = phase_q;
      pe_d    = pe_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            case (i_cmd)
               CMD_LOAD:    pe_d = i_load;
               CMD_SHIFT_L: pe_d = i_PE_l;
               CMD_SHIFT_R: pe_d = i_PE_r;
               CMD_SHIFT_U: pe_d = i_PE_u;
               CMD_SHIFT_D: pe_d = i_PE_d;
               CMD_SORT: begin
                  state_d = SORT;
                  step_d  = '0;
                  phase_d = '0;
                  busy_d  = 1'b1;
               end
               default: ;
            endcase
         end
         SORT: begin
            // Even phases sort rows in snake direction, odd phases sort columns downward.
            if (!phase_q[0]) begin
               if (colEven && HAS_R) begin
                  if (ASCEND) pe_d = (i_PE_r < pe_q) ? i_PE_r : pe_q;
                  else        pe_d = (i_PE_r > pe_q) ? i_PE_r : pe_q;
               end else if (!colEven && HAS_L) begin
                  if (ASCEND) pe_d = (i_PE_l > pe_q) ? i_PE_l : pe_q;
                  else        pe_d = (i_PE_l < pe_q) ? i_PE_l : pe_q;
               end
            end else begin
               if (rowEven && HAS_D)       pe_d = (i_PE_d < pe_q) ? i_PE_d : pe_q;
               else if (!rowEven && HAS_U) pe_d = (i_PE_u > pe_q) ? i_PE_u : pe_q;
            end
            if (step_q == STEP_LAST) begin
               step_d = '0;
               if (phase_q == PHASE_LAST) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  phase_d = phase_q + 1'b1;
               end
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         step_q  <= '0;
         phase_q <= '0;
         pe_q    <= RESET_VALUE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         phase_q <= phase_d;
         pe_q    <= pe_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign o_PE   = pe_q;
   assign o_busy = busy_q;
   assign o_done = done_q;

endmodule

// File: tb/tb_nanci_sort_pe.sv
// Bench for nanci_sort_pe: a lone PE, a 2x2 mesh and a 4x4 mesh, checked against a
// scoreboard of expected words that is filled when stimulus is applied.
module tb_nanci_sort_pe;

   localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3;
   localparam logic [2:0] SHU = 3'd4, SHD = 3'd5, SORTC = 3'd6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [7:0] expQ[$];

   // Lone PE, SQRT_N=1.
   logic [2:0] cmdS;
   logic [5:0] loadS, peS;
   logic       busyS, doneS;

   nanci_sort_pe #(.SQRT_N(1), .ROW(0), .COL(0), .ADDR_WIDTH(3), .DATA_WIDTH(3),
                   .PHASES(1), .RESET_VALUE(6'b111_000)) uSingle (
      .clk(clk), .rst(rst), .i_cmd(cmdS), .i_load(loadS),
      .i_PE_l(6'b000_001), .i_PE_r(6'b000_010), .i_PE_u(6'b000_011), .i_PE_d(6'b000_100),
      .o_PE(peS), .o_busy(busyS), .o_done(doneS));

   // 2x2 mesh.
   logic [2:0] cmd2;
   logic [5:0] load2 [2][2];
   logic [5:0] m2Pe  [2][2];
   logic       m2Busy[2][2];
   logic       m2Done[2][2];

   for (genvar r = 0; r < 2; r++) begin : g2r
      for (genvar c = 0; c < 2; c++) begin : g2c
         logic [5:0] nl, nr, nu, nd;
         if (c > 0) begin : gl assign nl = m2Pe[r][c-1]; end else begin : gl0 assign nl = '0; end
         if (c < 1) begin : gr assign nr = m2Pe[r][c+1]; end else begin : gr0 assign nr = '0; end
         if (r > 0) begin : gu assign nu = m2Pe[r-1][c]; end else begin : gu0 assign nu = '0; end
         if (r < 1) begin : gd assign nd = m2Pe[r+1][c]; end else begin : gd0 assign nd = '0; end
         nanci_sort_pe #(.SQRT_N(2), .ROW(r), .COL(c), .ADDR_WIDTH(3), .DATA_WIDTH(3),
                         .PHASES(3), .RESET_VALUE(6'd0)) uPe (
            .clk(clk), .rst(rst), .i_cmd(cmd2), .i_load(load2[r][c]),
            .i_PE_l(nl), .i_PE_r(nr), .i_PE_u(nu), .i_PE_d(nd),
            .o_PE(m2Pe[r][c]), .o_busy(m2Busy[r][c]), .o_done(m2Done[r][c]));
      end
   end

   // 4x4 mesh with 4-bit keys so a full permutation of 16 keys fits.
   logic [2:0] cmd4;
   logic [6:0] load4 [4][4];
   logic [6:0] m4Pe  [4][4];
   logic       m4Busy[4][4];
   logic       m4Done[4][4];

   for (genvar r = 0; r < 4; r++) begin : g4r
      for (genvar c = 0; c < 4; c++) begin : g4c
         logic [6:0] nl, nr, nu, nd;
         if (c > 0) begin : gl assign nl = m4Pe[r][c-1]; end else begin : gl0 assign nl = '0; end
         if (c < 3) begin : gr assign nr = m4Pe[r][c+1]; end else begin : gr0 assign nr = '0; end
         if (r > 0) begin : gu assign nu = m4Pe[r-1][c]; end else begin : gu0 assign nu = '0; end
         if (r < 3) begin : gd assign nd = m4Pe[r+1][c]; end else begin : gd0 assign nd = '0; end
         nanci_sort_pe #(.SQRT_N(4), .ROW(r), .COL(c), .ADDR_WIDTH(4), .DATA_WIDTH(3),
                         .PHASES(5), .RESET_VALUE(7'd0)) uPe (
            .clk(clk), .rst(rst), .i_cmd(cmd4), .i_load(load4[r][c]),
            .i_PE_l(nl), .i_PE_r(nr), .i_PE_u(nu), .i_PE_d(nd),
            .o_PE(m4Pe[r][c]), .o_busy(m4Busy[r][c]), .o_done(m4Done[r][c]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [7:0] e;
      rst = 1'b0;
      repeat (2) tick();
      expQ.push_back(8'd56);
      e = expQ.pop_front();
      total++;
      if ({2'b00, peS} !== e) begin $display("FAIL reset_pe got=%0d want=%0d", peS, e); bad++; end
      total++;
      if (busyS !== 1'b0 || doneS !== 1'b0) begin
         $display("FAIL reset_flags got busy=%0b done=%0b want 0 0", busyS, doneS); bad++;
      end
      total++;
      if (m2Pe[1][1] !== 6'd0 || m2Busy[0][0] !== 1'b0) begin
         $display("FAIL reset_mesh got pe=%0d busy=%0b want 0 0", m2Pe[1][1], m2Busy[0][0]); bad++;
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_shift();
      logic [2:0] cmds [4];
      logic [7:0] e;
      cmds = '{SHL, SHR, SHU, SHD};
      for (int i = 0; i < 4; i++) begin
         cmdS = cmds[i];
         expQ.push_back(8'(i + 1));
         tick();
         cmdS = NOP;
         e = expQ.pop_front();
         total++;
         if ({2'b00, peS} !== e) begin
            $display("FAIL shift_%0d got=%0d want=%0d", cmds[i], peS, e); bad++;
         end
      end
   endtask

   task automatic test_load_hold();
      logic [7:0] e;
      loadS = 6'b101_010;
      cmdS = LOAD;
      expQ.push_back(8'd42);
      tick();
      cmdS = NOP;
      loadS = 6'd0;
      for (int i = 0; i < 4; i++) begin
         e = expQ.pop_front();
         total++;
         if ({2'b00, peS} !== e) begin $display("FAIL load_hold_%0d got=%0d want=%0d", i, peS, e); bad++; end
         expQ.push_back(8'd42);
         tick();
      end
      void'(expQ.pop_front());
   endtask

   task automatic test_async_reset();
      loadS = 6'd5;
      cmdS = LOAD;
      tick();
      cmdS = NOP;
      total++;
      if (peS !== 6'd5) begin $display("FAIL async_pre got=%0d want=5", peS); bad++; end
      #2 rst = 1'b0;
      #1;
      total++;
      if (peS !== 6'd56 || busyS !== 1'b0) begin
         $display("FAIL async_reset got pe=%0d busy=%0b want 56 0", peS, busyS); bad++;
      end
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single_sort();
      loadS = 6'd42;
      cmdS = LOAD;
      tick();
      cmdS = SORTC;
      tick();
      cmdS = NOP;
      total++;
      if (busyS !== 1'b1 || doneS !== 1'b0) begin
         $display("FAIL single_start got busy=%0b done=%0b want 1 0", busyS, doneS); bad++;
      end
      tick();
      total++;
      if (busyS !== 1'b1 || doneS !== 1'b1) begin
         $display("FAIL single_done got busy=%0b done=%0b want 1 1", busyS, doneS); bad++;
      end
      tick();
      total++;
      if (busyS !== 1'b0 || doneS !== 1'b0 || peS !== 6'd42) begin
         $display("FAIL single_end got busy=%0b done=%0b pe=%0d want 0 0 42", busyS, doneS, peS); bad++;
      end
   endtask

   task automatic m2Load(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c, input logic [5:0] d);
      load2[0][0] = a; load2[0][1] = b; load2[1][0] = c; load2[1][1] = d;
      cmd2 = LOAD;
      tick();
      cmd2 = NOP;
   endtask

   task automatic m2CheckFinal(input string tag);
      logic [7:0] e;
      for (int i = 0; i < 4; i++) begin
         e = expQ.pop_front();
         total++;
         if ({2'b00, m2Pe[i/2][i%2]} !== e) begin
            $display("FAIL %s_pe%0d got=%0d want=%0d", tag, i, m2Pe[i/2][i%2], e); bad++;
         end
      end
   endtask

   task automatic test_mesh2_sort();
      int busyCnt = 0;
      int doneCnt = 0;
      int doneAt = -1;
      m2Load(6'd24, 6'd16, 6'd8, 6'd0);
      expQ.push_back(8'd0); expQ.push_back(8'd8); expQ.push_back(8'd24); expQ.push_back(8'd16);
      cmd2 = SORTC;
      tick();
      cmd2 = NOP;
      for (int k = 0; k < 20; k++) begin
         if (m2Busy[0][0]) busyCnt++;
         if (m2Done[0][0]) begin doneCnt++; doneAt = busyCnt; end
         if (k == 2) begin
            total++;
            if (m2Pe[0][0] !== 6'd16 || m2Pe[0][1] !== 6'd24 || m2Pe[1][0] !== 6'd8 || m2Pe[1][1] !== 6'd0) begin
               $display("FAIL mesh2_phase0 got=%0d,%0d,%0d,%0d want=16,24,8,0",
                        m2Pe[0][0], m2Pe[0][1], m2Pe[1][0], m2Pe[1][1]); bad++;
            end
         end
         tick();
      end
      total++;
      if (busyCnt != 7) begin $display("FAIL mesh2_busy_cycles got=%0d want=7", busyCnt); bad++; end
      total++;
      if (doneCnt != 1 || doneAt != 7) begin
         $display("FAIL mesh2_done got count=%0d at=%0d want 1 at 7", doneCnt, doneAt); bad++;
      end
      m2CheckFinal("mesh2_final");
   endtask

   task automatic test_mesh2_ignore();
      int n = 0;
      m2Load(6'd24, 6'd16, 6'd8, 6'd0);
      expQ.push_back(8'd0); expQ.push_back(8'd8); expQ.push_back(8'd24); expQ.push_back(8'd16);
      cmd2 = SORTC;
      tick();
      tick();
      load2[0][0] = 6'd63; load2[0][1] = 6'd63; load2[1][0] = 6'd63; load2[1][1] = 6'd63;
      cmd2 = LOAD;
      repeat (2) tick();
      cmd2 = NOP;
      while (m2Busy[0][0] && n < 30) begin tick(); n++; end
      total++;
      if (m2Busy[0][0] !== 1'b0) begin $display("FAIL ignore_timeout got busy=1 want 0"); bad++; end
      m2CheckFinal("ignore_final");
   endtask

   task automatic test_mesh2_abort();
      int sawDone = 0;
      int sawBusy = 0;
      m2Load(6'd24, 6'd16, 6'd8, 6'd0);
      cmd2 = SORTC;
      tick();
      cmd2 = NOP;
      repeat (3) tick();
      rst = 1'b0;
      #1;
      total++;
      if (m2Pe[0][0] !== 6'd0 || m2Pe[0][1] !== 6'd0 || m2Pe[1][0] !== 6'd0 || m2Pe[1][1] !== 6'd0 ||
          m2Busy[0][0] !== 1'b0 || m2Done[0][0] !== 1'b0) begin
         $display("FAIL abort_reset got pe00=%0d busy=%0b done=%0b want 0 0 0", m2Pe[0][0], m2Busy[0][0], m2Done[0][0]);
         bad++;
      end
      tick();
      rst = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (m2Done[0][0]) sawDone++;
         if (m2Busy[0][0]) sawBusy++;
      end
      total++;
      if (sawDone != 0 || sawBusy != 0) begin
         $display("FAIL abort_idle got done=%0d busy=%0d want 0 0", sawDone, sawBusy); bad++;
      end
   endtask

   task automatic test_mesh4_sort(input bit dup);
      logic [6:0] words [16];
      logic [6:0] tmp;
      logic [7:0] e;
      logic [6:0] prev;
      logic [6:0] cur;
      int j;
      int busyCnt = 0;
      int doneAt = -1;
      bit orderOk = 1'b1;
      for (int i = 0; i < 16; i++) words[i] = {4'(i), 3'($urandom_range(0, 7))};
      for (int i = 15; i > 0; i--) begin
         j = $urandom_range(0, i);
         tmp = words[i]; words[i] = words[j]; words[j] = tmp;
      end
      if (dup) for (int i = 0; i < 16; i++) words[i] = {4'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
      for (int i = 0; i < 16; i++) load4[i/4][i%4] = words[i];
      cmd4 = LOAD;
      tick();
      for (int a = 0; a < 15; a++)
         for (int b = 0; b < 15 - a; b++)
            if (words[b] > words[b+1]) begin tmp = words[b]; words[b] = words[b+1]; words[b+1] = tmp; end
      for (int i = 0; i < 16; i++) expQ.push_back({1'b0, words[i]});
      cmd4 = SORTC;
      tick();
      cmd4 = NOP;
      for (int k = 0; k < 40; k++) begin
         if (m4Busy[0][0]) busyCnt++;
         if (m4Done[0][0] && doneAt < 0) doneAt = busyCnt;
         tick();
      end
      total++;
      if (busyCnt != 21 || doneAt != 21) begin
         $display("FAIL mesh4_timing dup=%0d got busy=%0d done_at=%0d want 21 21", dup, busyCnt, doneAt); bad++;
      end
      for (int i = 0; i < 16; i++) begin
         cur = ((i / 4) % 2 == 0) ? m4Pe[i/4][i%4] : m4Pe[i/4][3 - i%4];
         if (i > 0 && (dup ? (cur < prev) : (cur <= prev))) orderOk = 1'b0;
         prev = cur;
         e = expQ.pop_front();
         total++;
         if ({1'b0, cur} !== e) begin
            $display("FAIL mesh4_snake dup=%0d idx=%0d got=%0d want=%0d", dup, i, cur, e); bad++;
         end
      end
      total++;
      if (orderOk !== 1'b1) begin $display("FAIL mesh4_order dup=%0d got=0 want=1", dup); bad++; end
   endtask

   initial begin
      rst = 1'b0;
      cmdS = NOP; cmd2 = NOP; cmd4 = NOP;
      loadS = '0;
      for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) load2[r][c] = '0;
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) load4[r][c] = '0;
      test_reset();
      test_shift();
      test_load_hold();
      test_async_reset();
      test_single_sort();
      test_mesh2_sort();
      test_mesh2_ignore();
      test_mesh2_abort();
      test_mesh4_sort(1'b0);
      test_mesh4_sort(1'b0);
      test_mesh4_sort(1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
